// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared defaults and helpers for the 2-D IDCT datapath
package idct_pkg;

  localparam int IDCT_N = 8;
  localparam int IDCT_W = 17;

  // Pointer width for an index running 0..n-1; never narrower than one bit.
  function automatic int ctr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Low bit of lane j in a packed vector of w-bit lanes.
  function automatic int lane_lo(input int j, input int w);
    return j * w;
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// rtl/transpose_bank.sv - one NxN sample bank with row write and row/column read
module transpose_bank
  import idct_pkg::*;
#(
  parameter int N = IDCT_N,
  parameter int W = IDCT_W
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ctr_w(N)-1:0]     wr_row,
  input  logic [N*W-1:0]          wr_data,
  input  logic [ctr_w(N)-1:0]     rd_idx,
  input  logic                    rd_mode,
  output logic [N*W-1:0]          rd_data
);

  localparam int CW = ctr_w(N);

  // mem[row][col]; left unreset, contents are qualified by the controller's flags
  logic [W-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_row][CW'(c)] <= wr_data[lane_lo(c, W) +: W];
      end
    end
  end

  // Bypass reads row rd_idx as stored; transpose gathers column rd_idx.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam logic [CW-1:0] JI = CW'(j);
    assign rd_data[j*W +: W] = rd_mode ? mem[rd_idx][JI] : mem[JI][rd_idx];
  end

endmodule

// File: rtl/transpose_pingpong_buf.sv
// rtl/transpose_pingpong_buf.sv - double-buffered NxN transpose between IDCT passes
module transpose_pingpong_buf
  import idct_pkg::*;
#(
  parameter int N = IDCT_N,
  parameter int W = IDCT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_bypass,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_first,
  output logic           out_last
);

  localparam int CW = ctr_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          wb, rb;
  logic [CW-1:0] wr, rc;
  logic [1:0]    full, full_nxt;
  logic [1:0]    mode;
  logic          in_fire, out_fire;
  logic          wr_last, rc_last;
  logic [N*W-1:0] rd_data0, rd_data1;

  assign in_ready  = ~full[wb];
  assign out_valid = full[rb];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wr_last   = (wr == LAST);
  assign rc_last   = (rc == LAST);

  assign out_data  = rb ? rd_data1 : rd_data0;
  assign out_first = out_valid & (rc == '0);
  assign out_last  = out_valid & rc_last;

  // Fill and free can never target the same bank on one edge: a bank is
  // written only while empty and read only while full.
  always_comb begin
    full_nxt = full;
    if (in_fire && wr_last) full_nxt[wb] = 1'b1;
    if (out_fire && rc_last) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb   <= 1'b0;
      rb   <= 1'b0;
      wr   <= '0;
      rc   <= '0;
      full <= '0;
      mode <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        if (wr == '0) mode[wb] <= in_bypass;
        if (wr_last) begin
          wr <= '0;
          wb <= ~wb;
        end else begin
          wr <= wr + 1'b1;
        end
      end
      if (out_fire) begin
        if (rc_last) begin
          rc <= '0;
          rb <= ~rb;
        end else begin
          rc <= rc + 1'b1;
        end
      end
    end
  end

  transpose_bank #(.N(N), .W(W)) u_bank0 (
    .clk     (clk),
    .we      (in_fire & ~wb),
    .wr_row  (wr),
    .wr_data (in_data),
    .rd_idx  (rc),
    .rd_mode (mode[0]),
    .rd_data (rd_data0)
  );

  transpose_bank #(.N(N), .W(W)) u_bank1 (
    .clk     (clk),
    .we      (in_fire & wb),
    .wr_row  (wr),
    .wr_data (in_data),
    .rd_idx  (rc),
    .rd_mode (mode[1]),
    .rd_data (rd_data1)
  );

endmodule

// File: tb/tb_transpose_pingpong_buf.sv
// tb/tb_transpose_pingpong_buf.sv - directed self-checking bench for transpose_pingpong_buf
module tb_transpose_pingpong_buf;
  import idct_pkg::*;

  localparam int N = 8;
  localparam int W = 17;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic          in_bypass = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic          out_first;
  logic          out_last;

  int checks = 0;
  int errors = 0;
  int exp_rc = 0;
  logic [VW-1:0] exp_q[$];

  transpose_pingpong_buf #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] val(input int blk, input int r, input int c);
    return W'(blk * 256 + 16 * r + c);
  endfunction

  function automatic logic [VW-1:0] mk_row(input int blk, input int r);
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) v[lane_lo(c, W) +: W] = val(blk, r, c);
    return v;
  endfunction

  function automatic logic [VW-1:0] mk_col(input int blk, input int c);
    logic [VW-1:0] v;
    for (int r = 0; r < N; r++) v[lane_lo(r, W) +: W] = val(blk, r, c);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every accepted output vector is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
        check("out_first", VW'(out_first), VW'(exp_rc == 0));
        check("out_last", VW'(out_last), VW'(exp_rc == N - 1));
        exp_rc = (exp_rc == N - 1) ? 0 : exp_rc + 1;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    exp_rc = 0;
    reset = 1'b1;
  endtask

  task automatic push_block(input int blk, input logic byp);
    for (int i = 0; i < N; i++) exp_q.push_back(byp ? mk_row(blk, i) : mk_col(blk, i));
  endtask

  task automatic send_row(input int blk, input int r, input logic byp);
    int n;
    in_valid = 1'b1;
    in_data = mk_row(blk, r);
    in_bypass = byp;
    n = 0;
    while (!in_ready && n < 64) begin
      step();
      n++;
    end
    if (n == 64) check("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int blk, input logic byp0, input logic byp_rest);
    push_block(blk, byp0);
    for (int r = 0; r < N; r++) send_row(blk, r, (r == 0) ? byp0 : byp_rest);
  endtask

  task automatic drain(output int cycles);
    out_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 200) begin
      step();
      cycles++;
    end
    check("drain_done", VW'(exp_q.size() == 0), 1);
  endtask

  initial begin
    int cyc;
    step();
    step();
    reset = 1'b1;

    check("rst_in_ready", VW'(in_ready), 1);
    check("rst_out_valid", VW'(out_valid), 0);
    check("rst_out_first", VW'(out_first), 0);
    check("rst_out_last", VW'(out_last), 0);

    // Single transposed block; output appears the cycle after the last row.
    out_ready = 1'b1;
    push_block(0, 1'b0);
    for (int r = 0; r < N; r++) begin
      if (r == N - 1) check("t1_valid_before", VW'(out_valid), 0);
      send_row(0, r, 1'b0);
    end
    check("t1_valid_after", VW'(out_valid), 1);
    check("t1_first_col", out_data, mk_col(0, 0));
    drain(cyc);

    // Three blocks streamed with no input stall and contiguous output.
    for (int b = 1; b <= 3; b++) push_block(b, 1'b0);
    for (int i = 0; i < 3 * N; i++) begin
      in_valid = 1'b1;
      in_data = mk_row(1 + i / N, i % N);
      in_bypass = 1'b0;
      check("stream_in_ready", VW'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      check("stream_contig", VW'(out_valid), 1);
      step();
      cyc++;
    end
    check("stream_tail", VW'(cyc), VW'(N));

    // Backpressure: both banks fill, the next row holds until block 4 drains.
    out_ready = 1'b0;
    send_block(4, 1'b0, 1'b0);
    send_block(5, 1'b0, 1'b0);
    push_block(6, 1'b0);
    in_valid = 1'b1;
    in_data = mk_row(6, 0);
    in_bypass = 1'b0;
    check("bp_in_ready", VW'(in_ready), 0);
    check("bp_hold_data0", out_data, mk_col(4, 0));
    for (int k = 0; k < 3; k++) step();
    check("bp_in_ready_held", VW'(in_ready), 0);
    check("bp_hold_data1", out_data, mk_col(4, 0));
    check("bp_out_valid", VW'(out_valid), 1);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      check("bp_wait_ready", VW'(in_ready), 0);
      step();
    end
    check("bp_release", VW'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int r = 1; r < N; r++) send_row(6, r, 1'b0);
    drain(cyc);

    // Bypass block, then a transposed block whose later rows toggle in_bypass.
    send_block(7, 1'b1, 1'b1);
    send_block(8, 1'b0, 1'b1);
    drain(cyc);

    // Reset mid-block discards the partial block.
    for (int r = 0; r < 5; r++) send_row(9, r, 1'b0);
    do_reset();
    check("mid_rst_out_valid", VW'(out_valid), 0);
    check("mid_rst_in_ready", VW'(in_ready), 1);
    send_block(10, 1'b0, 1'b0);
    drain(cyc);

    // Bank 1's last row and bank 0's last column fire on the same edge.
    do_reset();
    out_ready = 1'b0;
    send_block(11, 1'b0, 1'b0);
    check("sim_a_valid", VW'(out_valid), 1);
    out_ready = 1'b1;
    send_block(12, 1'b0, 1'b0);
    check("sim_out_valid", VW'(out_valid), 1);
    check("sim_out_first", VW'(out_first), 1);
    check("sim_in_ready", VW'(in_ready), 1);
    check("sim_remaining", VW'(exp_q.size()), VW'(N));
    check("sim_next_col", out_data, mk_col(12, 0));
    drain(cyc);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
